// File: rtl/usb1_ep_pkg.sv
// Shared defaults and types for the usb1_core endpoint FIFOs.
package usb1_ep_pkg;

    localparam int unsigned USB1_EP_DW    = 8;
    localparam int unsigned USB1_EP_DEPTH = 64;
    localparam int unsigned USB1_EP_AW    = $clog2(USB1_EP_DEPTH);

    // Fill level for a default-depth FIFO: 0..USB1_EP_DEPTH inclusive
    typedef logic [USB1_EP_AW:0] usb1_ep_lvl_t;

endpackage

// File: rtl/usb1_ep_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register is the FIFO's dout; memory contents are never reset.
module usb1_ep_ram #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when no read is performed
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/usb1_ep_fifo.sv
// Endpoint byte FIFO between usb1_core and the application: pointers,
// level counter, full/empty handshakes and sticky misuse flags.
module usb1_ep_fifo
    import usb1_ep_pkg::*;
#(
    parameter int unsigned DW    = USB1_EP_DW,
    parameter int unsigned DEPTH = USB1_EP_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic [DW-1:0] din,
    input  logic          we,
    output logic          full,
    output logic [DW-1:0] dout,
    input  logic          re,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          udf
);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   level_nxt;
    logic          wr_ok;
    logic          rd_ok;
    logic          ram_we;
    logic          ram_re;

    // Accept decisions and next fill level; flush overrides any traffic
    always_comb begin
        wr_ok     = we && !full;
        rd_ok     = re && !empty;
        ram_we    = wr_ok && !clr_i;
        ram_re    = rd_ok && !clr_i;
        level_nxt = level;
        if (clr_i) begin
            level_nxt = '0;
        end else if (wr_ok && !rd_ok) begin
            level_nxt = level + (AW+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            level_nxt = level - (AW+1)'(1);
        end
    end

    // Pointers, level, flags; full/empty registered from the next level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            empty <= (level_nxt == '0);
            if (clr_i) begin
                wp  <= '0;
                rp  <= '0;
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wp <= wp + AW'(1);
                end
                if (rd_ok) begin
                    rp <= rp + AW'(1);
                end
                if (we && full) begin
                    ovf <= 1'b1;
                end
                if (re && empty) begin
                    udf <= 1'b1;
                end
            end
        end
    end

    usb1_ep_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (ram_we),
        .waddr (wp),
        .wdata (din),
        .re    (ram_re),
        .raddr (rp),
        .rdata (dout)
    );

endmodule

// File: doc/usb1_ep_fifo.md
# usb1_ep_fifo

Synchronous byte FIFO that terminates one endpoint data port of `usb1_core` on the application side.
- **IN-direction instance:** the application writes and the core reads via `epN_re`/`epN_din`/`epN_empty`.
- **OUT-direction instance:** the core writes via `epN_we`/`epN_dout`/`epN_full` and the application reads.
- The FIFO tracks fill level, flags misuse, and drives the core's full/empty handshakes.
- One instance pair per endpoint is placed beside the core.

## Interface
Parameters:
- `DW`, 8, data width in bits.
- `DEPTH`, 64, entries; power of two, minimum 4.
- `AW`, `$clog2(DEPTH)`, pointer width; derived, never overridden.

Ports:
- `clk_i`  in  1  core clock; all state on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `clr_i`  in  1  synchronous flush; empties FIFO and clears error flags.
- `din`  in  DW  write data.
- `we`  in  1  write strobe.
- `full`  out  1  no free entry.
- `dout`  out  DW  read data, registered.
- `re`  in  1  read strobe.
- `empty`  out  1  no stored entry.
- `level`  out  AW+1  entries stored, 0..DEPTH.
- `ovf`  out  1  sticky: write attempted while full.
- `udf`  out  1  sticky: read attempted while empty.

## Operation
- **Storage:** DEPTH×DW memory with write pointer `wp` and read pointer `rp`, each AW bits, wrapping modulo DEPTH. `level` is a separate AW+1-bit counter.
- **Accepted write:** `we && !full`. Stores `din` at `wp`, increments `wp`.
- **Accepted read:** `re && !empty`. Loads `mem[rp]` into `dout`, increments `rp`.
- **Level:** +1 on write-only, −1 on read-only, unchanged when both are accepted.
- **Write while full:** ignored, even if `re` is accepted the same cycle. Sets `ovf`.
- **Read while empty:** ignored, even if `we` is accepted the same cycle. `dout` holds. Sets `udf`.
- **Flags:** `full = (level == DEPTH)`, `empty = (level == 0)`. Both are decoded from the registered `level`, so they are glitch-free and change only on clock edges.
- **Flush:** `clr_i` has priority over `we`/`re` in the same cycle. It zeroes `wp`, `rp`, `level`, `ovf` and `udf`; `dout` holds; memory contents are not cleared.
- **Reset values:** `level` = 0, `empty` = 1, `full` = 0, `dout` = 0, `ovf` = 0, `udf` = 0, `wp` = `rp` = 0.
- **Reset mid-transfer:** asserting `rst_i` mid-transfer discards all contents immediately, without waiting for a clock edge.

## Timing
- **Write to flag:** a write accepted at edge N updates `level`/`empty` at edge N; `empty` falls in the cycle after the strobe.
- **Read latency:** a read accepted at edge N presents data on `dout` from edge N until the next accepted read. This matches the core sampling `epN_din` one cycle after `epN_re`.
- **No fall-through:** data written at edge N is readable by a `re` sampled at edge N+1 at the earliest.
- **Back-to-back:** 1 write + 1 read per cycle sustained indefinitely at any level from 1 to DEPTH−1. At DEPTH, only the read is accepted; at 0, only the write.
- **Flag update:** `full` rises on the edge that accepts the DEPTH-th write and falls on the edge that accepts a read.
- **Pointer wrap:** no bubble at wrap-around; `wp` = DEPTH−1 → 0 like any other increment.

## Structure
- **Package `usb1_ep_pkg`:**
  - `USB1_EP_DW` = 8 and `USB1_EP_DEPTH` = 64 default constants.
  - `usb1_ep_lvl_t` level typedef, sized from the default depth.
- **Sub-module `usb1_ep_ram`:** simple dual-port RAM with one write port and one registered read port with read enable. It holds the `dout` register so synthesis infers block RAM.
- **Top level:** pointers, level counter, flags and error logic.
- **No other hierarchy:** the wrapper instantiates 2×7 copies of `usb1_ep_fifo`.

## Test plan
- **Fill to full (DEPTH=4):** after reset, write 0x11,0x22,0x33,0x44 on consecutive cycles → `level` reads 1,2,3,4. `full` = 1 after the 4th edge; `empty` = 0 after the 1st.
- **Overflow:** with the FIFO full, write 0x55 → contents unchanged, `ovf` = 1, `level` = 4. Then read 4 times → `dout` = 0x11,0x22,0x33,0x44, each one cycle after its `re`, and `empty` = 1.
- **Underflow:** with the FIFO empty and `dout` = 0x44, pulse `re` with `we` = 1, `din` = 0x66 → `udf` = 1, `dout` stays 0x44, `level` = 1. The next read returns 0x66.
- **Sustained simultaneous traffic:** preload 2 entries, then 20 cycles of `we` and `re` with an incrementing pattern → `level` stays 2 and data emerges in order across 5 pointer wraps.
- **Flush priority:** with `level` = 3 and `ovf` = 1, assert `clr_i` together with `we` → `level` = 0, `empty` = 1, `ovf` = 0; the write is discarded.
- **Asynchronous reset:** assert `rst_i` between clock edges at `level` = 2 → `level` = 0, `empty` = 1, `dout` = 0 before the next edge.
